// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RISC-V control path: opcodes, ALU op, mux selects and FSM states.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_ILLEGAL
    } state_t;

    // Per-state Moore control word; mem_ready/zero gating is applied at the outputs.
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       fetch;
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic       illegal;
        logic       done;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
    } ctrl_t;

endpackage

// File: rtl/imm_src_decoder.sv
// Combinational immediate-format decode from the opcode field.
module imm_src_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_LW, OP_I: imm_src = IMM_I;
            OP_SW:       imm_src = IMM_S;
            OP_BEQ:      imm_src = IMM_B;
            OP_JAL:      imm_src = IMM_J;
            default:     imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/main_ctrl_fsm.sv
// Multi-cycle RISC-V main controller: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects, write enables and the memory handshake.
module main_ctrl_fsm
    import rv_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic       illegal_instr,
    output logic       instr_done
);

    state_t state_q, state_d;
    ctrl_t  ctrl_q;
    logic   rdy;

    assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

    function automatic ctrl_t decode(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.fetch      = 1'b1;
                c.pc_update  = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALU_ADD;
                c.result_src = RES_ALU;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
            end
            S_MEMREAD: begin
                c.mem_req    = 1'b1;
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                c.result_src = RES_RDATA;
                c.reg_write  = 1'b1;
                c.done       = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_req    = 1'b1;
                c.mem_write  = 1'b1;
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
            end
            S_EXECR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALU_FUNCT;
            end
            S_EXECI: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
                c.done       = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a  = SRCA_RS1;
                c.alu_src_b  = SRCB_RS2;
                c.alu_op     = ALU_SUB;
                c.result_src = RES_ALUOUT;
                c.branch     = 1'b1;
                c.done       = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALU_ADD;
                c.result_src = RES_ALUOUT;
                c.pc_update  = 1'b1;
            end
            S_ILLEGAL: begin
                c.illegal = 1'b1;
                c.done    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = rdy ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_ILLEGAL:  state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Control word is registered alongside the state so outputs come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            ctrl_q  <= decode(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode(state_d);
        end
    end

    // Strobes are masked by rst directly so an abort takes effect without waiting for a flop.
    assign mem_req       = ctrl_q.mem_req & ~rst;
    assign mem_write     = ctrl_q.mem_write & ~rst;
    assign ir_write      = ctrl_q.fetch & rdy & ~rst;
    assign pc_write      = ((ctrl_q.pc_update & (~ctrl_q.fetch | rdy)) | (ctrl_q.branch & zero))
                           & ~rst;
    assign reg_write     = ctrl_q.reg_write & ~rst;
    assign illegal_instr = ctrl_q.illegal & ~rst;
    assign instr_done    = (ctrl_q.done | (ctrl_q.mem_write & rdy)) & ~rst;
    assign adr_src       = ctrl_q.adr_src;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign alu_op        = ctrl_q.alu_op;
    assign result_src    = ctrl_q.result_src;

    imm_src_decoder u_imm_src_decoder (
        .op      (op),
        .imm_src (imm_src)
    );

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Randomized bench for main_ctrl_fsm: per-instruction cycle scripts built from the
// instruction-level behaviour, compared against the DUT every cycle.
module tb_main_ctrl_fsm;
    import rv_ctrl_pkg::*;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, imm_src;
    logic       illegal_instr, instr_done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [6:0]  op;
        logic        mr;
        logic        z;
        logic [15:0] exp;
    } step_t;

    step_t script[$];

    main_ctrl_fsm #(.MEM_HANDSHAKE(1'b1)) dut (
        .clk           (clk),
        .rst           (rst),
        .op            (op),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_write     (mem_write),
        .adr_src       (adr_src),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .result_src    (result_src),
        .imm_src       (imm_src),
        .illegal_instr (illegal_instr),
        .instr_done    (instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal, done, a, b, aluop, res}
    function automatic logic [15:0] pk(bit mq, bit mw, bit ad, bit irw, bit pcw, bit rw,
                                       bit ill, bit dn, logic [1:0] a, logic [1:0] b,
                                       logic [1:0] ao, logic [1:0] rs);
        return {mq, mw, ad, irw, pcw, rw, ill, dn, a, b, ao, rs};
    endfunction

    function automatic logic [15:0] observed();
        return {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal_instr,
                instr_done, alu_src_a, alu_src_b, alu_op, result_src};
    endfunction

    function automatic logic [1:0] exp_imm(logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic bit is_legal(logic [6:0] o);
        return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                         7'b1100011, 7'b1101111};
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom_range(0, 127));
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic [6:0] o, input logic mr, input logic z,
                        input logic [15:0] e);
        step_t s;
        s.op  = o;
        s.mr  = mr;
        s.z   = z;
        s.exp = e;
        script.push_back(s);
    endtask

    // kind: 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal, 6 illegal; zsel 2 = random zero
    task automatic gen(input int kind, input int fw, input int mw, input int zsel);
        logic [6:0] o;
        logic       z;
        case (kind)
            0: o = 7'b0000011;
            1: o = 7'b0100011;
            2: o = 7'b0110011;
            3: o = 7'b0010011;
            4: o = 7'b1100011;
            5: o = 7'b1101111;
            default: begin
                o = rop();
                while (is_legal(o)) o = rop();
            end
        endcase
        // Fetch: the IR still holds stale contents, so op is arbitrary here
        for (int i = 0; i < fw; i++)
            push(rop(), 1'b0, rbit(), pk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10));
        push(rop(), 1'b1, rbit(), pk(1, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10));
        push(o, rbit(), rbit(), pk(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00));
        case (kind)
            0, 1: begin
                push(o, rbit(), rbit(), pk(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00));
                for (int i = 0; i < mw; i++)
                    push(o, 1'b0, rbit(), pk(1, kind == 1, 1, 0, 0, 0, 0, 0,
                                             2'b00, 2'b00, 2'b00, 2'b00));
                push(o, 1'b1, rbit(), pk(1, kind == 1, 1, 0, 0, 0, 0, kind == 1,
                                         2'b00, 2'b00, 2'b00, 2'b00));
                if (kind == 0)
                    push(o, rbit(), rbit(), pk(0, 0, 0, 0, 0, 1, 0, 1,
                                               2'b00, 2'b00, 2'b00, 2'b01));
            end
            2, 3: begin
                push(o, rbit(), rbit(), pk(0, 0, 0, 0, 0, 0, 0, 0, 2'b10,
                                           (kind == 2) ? 2'b00 : 2'b01, 2'b10, 2'b00));
                push(o, rbit(), rbit(), pk(0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00));
            end
            4: begin
                z = (zsel == 2) ? rbit() : zsel[0];
                push(o, rbit(), z, pk(0, 0, 0, 0, z, 0, 0, 1, 2'b10, 2'b00, 2'b01, 2'b00));
            end
            5: begin
                push(o, rbit(), rbit(), pk(0, 0, 0, 0, 1, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00));
                push(o, rbit(), rbit(), pk(0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00));
            end
            default:
                push(o, rbit(), rbit(), pk(0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00));
        endcase
    endtask

    task automatic run(input int n);
        step_t s;
        for (int i = 0; i < n && script.size() > 0; i++) begin
            s = script.pop_front();
            @(negedge clk);
            op        = s.op;
            mem_ready = s.mr;
            zero      = s.z;
            #2;
            check("ctrl", 32'(observed()), 32'(s.exp));
            check("imm_src", 32'(imm_src), 32'(exp_imm(s.op)));
        end
    endtask

    localparam logic [15:0] RST_EXP = 16'b0000_0000_00_10_00_10;

    initial begin
        rst       = 1'b1;
        op        = 7'b0000011;
        zero      = 1'b1;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        check("reset_outputs", 32'(observed()), 32'(RST_EXP));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed cases
        gen(2, 0, 0, 0);
        gen(0, 0, 2, 0);
        gen(4, 0, 0, 1);
        gen(4, 0, 0, 0);
        gen(5, 0, 0, 0);
        gen(6, 0, 0, 0);
        gen(3, 3, 0, 0);
        gen(1, 0, 1, 0);
        run(1000);

        // Abort a store mid-wait: fetch, decode, memadr, first MEMWRITE wait cycle
        gen(1, 0, 4, 0);
        run(4);
        script.delete();
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_mem_write", 32'(mem_write), 32'd0);
        check("rst_async_mem_req", 32'(mem_req), 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_outputs", 32'(observed()), 32'(RST_EXP));
        mem_ready = 1'b0;
        rst       = 1'b0;
        gen(2, 1, 0, 0);
        run(1000);

        for (int k = 0; k < 300; k++) begin
            gen($urandom_range(0, 6), $urandom_range(0, 2), $urandom_range(0, 3), 2);
            run(1000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/main_ctrl_fsm.md
Name: main_ctrl_fsm

Overview:
- Multi-cycle RISC-V control unit. It is the upstream producer of the 2-bit alu_op consumed by the ALU decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Drives datapath mux selects and write enables.
- Handshakes with instruction/data memory through mem_req/mem_ready.
- Supports lw, sw, R-type, I-type ALU, beq and jal.

Parameters:
MEM_HANDSHAKE, 1, when 0 mem_ready is ignored and treated as constant 1 (zero-wait memory)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
op  input  7  opcode field from the instruction register
zero  input  1  ALU zero flag
mem_ready  input  1  memory access complete this cycle
mem_req  output  1  memory access request
mem_write  output  1  memory write strobe
adr_src  output  1  memory address select: 0 = PC, 1 = registered ALU result
ir_write  output  1  load instruction register and old-PC register
pc_write  output  1  load PC
reg_write  output  1  register file write enable
alu_src_a  output  2  00 = PC, 01 = old PC, 10 = rs1 data
alu_src_b  output  2  00 = rs2 data, 01 = immediate, 10 = constant 4
alu_op  output  2  00 = add, 01 = subtract, 10 = decode from funct3/funct7
result_src  output  2  00 = ALU-out register, 01 = read data, 10 = live ALU result
imm_src  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
illegal_instr  output  1  one-cycle pulse on an unsupported opcode
instr_done  output  1  one-cycle pulse in the last state of each instruction

Behaviour:
- Reset: rst is asynchronous and active-high. State forced to FETCH.
- While rst is high, mem_req, mem_write, ir_write, pc_write, reg_write, illegal_instr and instr_done are forced to 0. Selects take their FETCH values.
- Reset asserted in any state aborts the instruction with no partial register or memory write.
- Outputs are Moore (decoded from state only). Exceptions:
  - pc_write = pc_update | (branch & zero).
  - ir_write and pc_update in FETCH are gated by mem_ready.
  - imm_src is combinational from op: 0000011/0010011 -> 00, 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, any other -> 00.
- Any output not listed for a state is 0. The ALU-out register is datapath-owned.
- FETCH:
  - Outputs: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. ir_write=pc_update=mem_ready.
  - Stays while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target computed into ALU-out).
  - Next state by op: lw/sw -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BEQ, 1101111 -> JAL, else -> ILLEGAL.
- MEMADR:
  - Outputs: alu_src_a=10, alu_src_b=01, alu_op=00.
  - Next state: lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD:
  - Outputs: mem_req=1, adr_src=1, result_src=00.
  - Waits for mem_ready, then -> MEMWB.
- MEMWB:
  - Outputs: result_src=01, reg_write=1, instr_done=1.
  - Next state: FETCH.
- MEMWRITE:
  - Outputs: mem_req=1, mem_write=1, adr_src=1, result_src=00.
  - On mem_ready: instr_done=1, -> FETCH. mem_write is held high across all wait cycles.
- EXECR:
  - Outputs: alu_src_a=10, alu_src_b=00, alu_op=10.
  - Next state: ALUWB.
- EXECI:
  - Outputs: alu_src_a=10, alu_src_b=01, alu_op=10.
  - Next state: ALUWB.
- ALUWB:
  - Outputs: result_src=00, reg_write=1, instr_done=1.
  - Next state: FETCH.
- BEQ:
  - Outputs: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1, instr_done=1.
  - Next state: FETCH.
- JAL:
  - Outputs: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1.
  - Next state: ALUWB (writes PC+4 to rd).
- ILLEGAL:
  - Outputs: illegal_instr=1, instr_done=1.
  - Next state: FETCH. No register, memory or PC writes.
- Latency with zero wait:
  - lw: 5 cycles; sw, R-type, I-type, jal: 4 cycles; beq: 3 cycles; illegal: 3 cycles.
  - Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds 1 cycle.
- mem_ready is sampled only while mem_req=1. mem_ready high outside those states has no effect.
- op is sampled only in DECODE and MEMADR. It is stable because the instruction register is loaded only in FETCH.

Decomposition:
- Shared package rv_ctrl_pkg:
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL);
  - alu_op encodings; state encoding (4 bits);
  - alu_src_a, alu_src_b, result_src and imm_src select encodings.
- Natural sub-module: imm_src_decoder (combinational op -> imm_src), reusable by a future pipelined control unit.
- State register, next-state logic and output decode stay in main_ctrl_fsm.

Test Plan:
- Reset handling: assert rst while in MEMWRITE with mem_ready=0 -> mem_write drops to 0 immediately (asynchronous); after release, state=FETCH and no reg_write pulse is seen.
- R-type (op=0110011), mem_ready=1 -> states FETCH, DECODE, EXECR, ALUWB in 4 cycles; alu_op=10 in EXECR; reg_write=1 and instr_done=1 in cycle 4 only.
- lw (op=0000011) with 2 wait cycles in MEMREAD -> MEMREAD lasts 3 cycles with adr_src=1 throughout; MEMWB has result_src=01 and reg_write=1; total 7 cycles.
- beq (op=1100011) with zero=1, then zero=0 -> pc_write=1 in the BEQ state for the first instruction and 0 for the second; alu_op=01 in both.
- jal (op=1101111) -> pc_write=1 in JAL; ALUWB writes with result_src=00; imm_src=11 throughout.
- Illegal opcode op=1111111 -> illegal_instr pulses for exactly 1 cycle; reg_write, mem_write and pc_write stay 0; next state is FETCH. FETCH with mem_ready=0 for 3 cycles -> ir_write=0 and pc_write=0 until mem_ready rises.
